// File: rtl/bf16_stream_convert.sv
// Purpose: converts LANES parallel lanes between f32 and bf16 (pack with RNE or RTZ, unpack), mode chosen per beat.
// Latency: 2 cycles from input handshake to out_valid_o; one beat per cycle sustained while out_ready_i is high.
// Backpressure: one advance signal stalls both stages together; in_ready_o = !out_valid_o | out_ready_i.
module bf16_stream_convert #(
  parameter int unsigned LANES = 4,
  parameter bit          FTZ   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  mode_i,
  input  logic                  rnd_i,
  input  logic [32*LANES-1:0]   data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [32*LANES-1:0]   data_o,
  output logic [1:0]            flags_o,
  input  logic                  clr_i,
  output logic [1:0]            sticky_o,
  output logic [15:0]           beat_cnt_o
);

  localparam int unsigned DW = 32 * LANES;

  // One lane's converted word plus its {overflow, inexact} contribution.
  typedef struct packed {
    logic        ovf;
    logic        inx;
    logic [31:0] dat;
  } lane_res_t;

  // f32 -> bf16. NaN and Inf bypass rounding; a finite input that rounds
  // up into exponent 0xFF becomes signed Inf and reports overflow. RTZ
  // never increments, so it can never reach exponent 0xFF from a finite input.
  function automatic lane_res_t pack_lane(input logic [31:0] f, input logic rtz);
    lane_res_t   r;
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    logic        inc;
    logic [15:0] sum;
    r     = '0;
    exp_f = f[30:23];
    man_f = f[22:0];
    // Round-to-nearest-even: round bit set and (sticky or odd lsb).
    inc   = ~rtz & f[15] & ((|f[14:0]) | f[16]);
    // Top half of a finite input is at most 0xFF7F, so the add cannot wrap.
    sum   = f[31:16] + {15'd0, inc};
    if (exp_f == 8'hFF) begin
      if (man_f != '0) begin
        // Quiet the NaN and keep the top six payload bits.
        r.dat[15:0] = {f[31], 8'hFF, 1'b1, f[21:16]};
      end else begin
        r.dat[15:0] = f[31:16];
      end
    end else if (FTZ && (exp_f == 8'h00)) begin
      r.dat[15:0] = {f[31], 15'd0};
      r.inx       = |man_f;
    end else begin
      r.dat[15:0] = sum;
      r.ovf       = (sum[14:7] == 8'hFF);
      r.inx       = |f[15:0];
    end
    return r;
  endfunction

  // bf16 -> f32 is exact; only the flush-to-zero path can lose information.
  function automatic lane_res_t unpack_lane(input logic [15:0] b);
    lane_res_t r;
    r = '0;
    if (FTZ && (b[14:7] == 8'h00)) begin
      r.dat = {b[15], 31'd0};
      r.inx = |b[6:0];
    end else begin
      r.dat = {b, 16'h0000};
    end
    return r;
  endfunction

  logic            adv;
  logic            s1_vld;
  logic [DW-1:0]   s1_dat;
  logic            s1_mode;
  logic            s1_rnd;
  logic [DW-1:0]   res_dat;
  logic [1:0]      res_flg;
  lane_res_t       lane_res;
  logic            out_hs;

  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv;
  assign out_hs     = out_valid_o & out_ready_i;

  // Stage 1: capture the accepted beat with its per-beat mode and rounding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      s1_mode <= 1'b0;
      s1_rnd  <= 1'b0;
    end else if (adv) begin
      s1_vld <= in_valid_i;
      if (in_valid_i) begin
        s1_dat  <= data_i;
        s1_mode <= mode_i;
        s1_rnd  <= rnd_i;
      end
    end
  end

  // Convert every lane of the stage-1 beat and OR the lane flags together.
  always_comb begin
    res_dat  = '0;
    res_flg  = '0;
    lane_res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_mode) begin
        lane_res = unpack_lane(s1_dat[32*k +: 16]);
      end else begin
        lane_res = pack_lane(s1_dat[32*k +: 32], s1_rnd);
      end
      res_dat[32*k +: 32] = lane_res.dat;
      res_flg             = res_flg | {lane_res.ovf, lane_res.inx};
    end
  end

  // Stage 2: register results; bubbles leave the last data/flags in place.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      data_o      <= '0;
      flags_o     <= '0;
    end else if (adv) begin
      out_valid_o <= s1_vld;
      if (s1_vld) begin
        data_o  <= res_dat;
        flags_o <= res_flg;
      end
    end
  end

  // Statistics: clear wins over a same-cycle handshake, count saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sticky_o   <= '0;
      beat_cnt_o <= '0;
    end else if (out_hs) begin
      sticky_o <= sticky_o | flags_o;
      if (beat_cnt_o != 16'hFFFF) begin
        beat_cnt_o <= beat_cnt_o + 16'd1;
      end
    end
  end

endmodule
